// File: rtl/exec_wakeup_bcast.sv
`default_nettype none
// ============================================================================
// Module   : exec_wakeup_bcast
// Purpose  : Fixed-latency execution pipe feeding an in-order completion FIFO
//            that broadcasts one wakeup (executed/executedReg) per cycle.
// Revision : 1.0
// ============================================================================

module exec_wakeup_bcast #(
   parameter int LAT   = 2,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             numIssued,
   input  logic [6:0]             issued0,
   input  logic [6:0]             issued1,
   input  logic [6:0]             issued2,
   input  logic [6:0]             issued3,
   input  logic [7:0]             dest0,
   input  logic [7:0]             dest1,
   input  logic [7:0]             dest2,
   input  logic [7:0]             dest3,
   output logic                   executed,
   output logic [7:0]             executedReg,
   output logic [6:0]             doneRobIdx,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   overflow
);

   localparam int c_AW = $clog2(DEPTH);

   typedef logic [c_AW-1:0] ptr_t;
   typedef logic [c_AW:0]   occ_t;
   typedef logic [14:0]     entry_t;    // {robIdx, dest}

   entry_t     w_slot [4];
   logic       w_violate;
   logic       w_clamp;
   logic [2:0] w_req_cnt;
   logic [2:0] w_acc_cnt;
   logic [2:0] w_push_cnt;
   logic       w_pop;
   logic [4:0] w_inflight;
   logic [6:0] w_level;

   // Pipe stage s+1 lives at index s
   entry_t     r_pipe [LAT][4];
   logic [2:0] r_cnt  [LAT];

   entry_t     r_mem [DEPTH];
   ptr_t       r_wr_ptr;
   ptr_t       r_rd_ptr;
   occ_t       r_occ;

   always_comb begin
      w_slot[0] = {issued0, dest0};
      w_slot[1] = {issued1, dest1};
      w_slot[2] = {issued2, dest2};
      w_slot[3] = {issued3, dest3};
   end

   assign w_violate  = (numIssued != 3'd0) && stall;
   assign w_clamp    = (numIssued > 3'd4);
   assign w_req_cnt  = w_clamp ? 3'd4 : numIssued;
   assign w_acc_cnt  = w_violate ? 3'd0 : w_req_cnt;

   assign w_push_cnt = r_cnt[LAT-1];
   assign w_pop      = (r_occ != '0);

   always_comb begin
      w_inflight = '0;
      for (int s = 0; s < LAT; s++) begin
         w_inflight = w_inflight + {2'b00, r_cnt[s]};
      end
   end

   // Headroom of four entries means any group accepted now always fits later
   assign w_level   = 7'(r_occ) + 7'(w_inflight);
   assign stall     = (w_level > 7'(DEPTH - 4));
   assign occupancy = r_occ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < LAT; s++) begin
            r_cnt[s] <= '0;
            for (int k = 0; k < 4; k++) begin
               r_pipe[s][k] <= '0;
            end
         end
      end else begin
         r_cnt[0] <= w_acc_cnt;
         for (int k = 0; k < 4; k++) begin
            r_pipe[0][k] <= w_slot[k];
         end
         for (int s = 1; s < LAT; s++) begin
            r_cnt[s]  <= r_cnt[s-1];
            r_pipe[s] <= r_pipe[s-1];
         end
      end
   end

   // Storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < w_push_cnt) begin
            r_mem[r_wr_ptr + ptr_t'(k)] <= r_pipe[LAT-1][k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occ       <= '0;
         executed    <= 1'b0;
         executedReg <= '0;
         doneRobIdx  <= '0;
         overflow    <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + ptr_t'(w_push_cnt);
         r_occ    <= r_occ + occ_t'(w_push_cnt) - occ_t'(w_pop);
         if (w_pop) begin
            r_rd_ptr                  <= r_rd_ptr + ptr_t'(1);
            executed                  <= 1'b1;
            {doneRobIdx, executedReg} <= r_mem[r_rd_ptr];
         end else begin
            executed    <= 1'b0;
            executedReg <= '0;
            doneRobIdx  <= '0;
         end
         if (w_violate || w_clamp) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_exec_wakeup_bcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_wakeup_bcast
// Purpose  : Scoreboard bench for exec_wakeup_bcast (LAT=2, DEPTH=16 and 8).
// Revision : 1.0
// ============================================================================

module tb_exec_wakeup_bcast;

   localparam int LAT   = 2;
   localparam int DEPTH = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] num  = '0;
   logic [6:0] rob [4];
   logic [7:0] dst [4];
   logic       executed;
   logic [7:0] executed_reg;
   logic [6:0] done_rob;
   logic       stall;
   logic [4:0] occupancy;
   logic       overflow;

   logic [2:0] num8 = '0;
   logic [6:0] rob8 [4];
   logic [7:0] dst8 [4];
   logic       executed8;
   logic [7:0] executed_reg8;
   logic [6:0] done_rob8;
   logic       stall8;
   logic [3:0] occupancy8;
   logic       overflow8;

   exec_wakeup_bcast #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(rst_n), .numIssued(num),
      .issued0(rob[0]), .issued1(rob[1]), .issued2(rob[2]), .issued3(rob[3]),
      .dest0(dst[0]), .dest1(dst[1]), .dest2(dst[2]), .dest3(dst[3]),
      .executed(executed), .executedReg(executed_reg), .doneRobIdx(done_rob),
      .stall(stall), .occupancy(occupancy), .overflow(overflow)
   );

   exec_wakeup_bcast #(.LAT(LAT), .DEPTH(8)) dut8 (
      .clk(clk), .reset(rst_n), .numIssued(num8),
      .issued0(rob8[0]), .issued1(rob8[1]), .issued2(rob8[2]), .issued3(rob8[3]),
      .dest0(dst8[0]), .dest1(dst8[1]), .dest2(dst8[2]), .dest3(dst8[3]),
      .executed(executed8), .executedReg(executed_reg8), .doneRobIdx(done_rob8),
      .stall(stall8), .occupancy(occupancy8), .overflow(overflow8)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model of the 16-deep instance; sb holds accepted ops in order
   int          m_c [LAT];
   int          m_occ;
   logic        m_stall, m_ovf, m_exec;
   logic [14:0] m_exp;
   logic [14:0] sb [$];

   function automatic int m_level();
      int l = m_occ;
      for (int s = 0; s < LAT; s++) l += m_c[s];
      return l;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int acc;
      int pop;
      if (!rst_n) begin
         for (int s = 0; s < LAT; s++) m_c[s] = 0;
         m_occ = 0; m_stall = 1'b0; m_ovf = 1'b0; m_exec = 1'b0; m_exp = '0;
         sb.delete();
      end else begin
         acc = (num > 3'd4) ? 4 : int'(num);
         if (num > 3'd4) m_ovf = 1'b1;
         if (num != 3'd0 && m_stall) begin
            acc   = 0;
            m_ovf = 1'b1;
         end
         for (int k = 0; k < acc; k++) sb.push_back({rob[k], dst[k]});
         pop = (m_occ != 0) ? 1 : 0;
         if (pop == 1) begin
            m_exec = 1'b1;
            m_exp  = sb.pop_front();
         end else begin
            m_exec = 1'b0;
            m_exp  = '0;
         end
         m_occ = m_occ + m_c[LAT-1] - pop;
         for (int s = LAT - 1; s > 0; s--) m_c[s] = m_c[s-1];
         m_c[0]  = acc;
         m_stall = (m_level() > DEPTH - 4);
      end
   end

   int          peak = 0, run = 0, max_run = 0;
   logic        saw_stall = 1'b0;
   logic [14:0] sb8 [$];
   logic [14:0] e8;
   int          bc8 = 0, max_occ8 = 0;

   always @(negedge clk) begin
      chk("executed",    executed,     m_exec);
      chk("executedReg", executed_reg, m_exp[7:0]);
      chk("doneRobIdx",  done_rob,     m_exp[14:8]);
      chk("occupancy",   occupancy,    m_occ);
      chk("stall",       stall,        m_stall);
      chk("overflow",    overflow,     m_ovf);
      if (occupancy > peak) peak = occupancy;
      run = executed ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (stall) saw_stall = 1'b1;
      if (occupancy8 > max_occ8) max_occ8 = occupancy8;
      if (executed8) begin
         bc8++;
         chk("wrap_sb_nonempty", (sb8.size() != 0), 1);
         if (sb8.size() != 0) begin
            e8 = sb8.pop_front();
            chk("wrap_rob",  done_rob8,     e8[14:8]);
            chk("wrap_dest", executed_reg8, e8[7:0]);
         end
      end
   end

   int next_rob = 0;

   task automatic issue(input int n);
      for (int k = 0; k < 4; k++) begin
         rob[k] = 7'(next_rob + k);
         dst[k] = 8'($urandom);
      end
      next_rob += 4;
      num = 3'(n);
      @(posedge clk); #1;
      num = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int ok = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (occupancy == 0 && !executed && m_level() == 0) begin
            ok = 1;
            break;
         end
      end
      chk(tag, ok, 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int issued8;
      int n;
      int ok;
      int stale;
      for (int k = 0; k < 4; k++) begin
         rob[k] = '0; dst[k] = '0; rob8[k] = '0; dst8[k] = '0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_executed",  executed,     0);
      chk("rst_reg",       executed_reg, 0);
      chk("rst_rob",       done_rob,     0);
      chk("rst_occupancy", occupancy,    0);
      chk("rst_stall",     stall,        0);
      chk("rst_overflow",  overflow,     0);
      rst_n = 1'b1;

      // Single op: broadcast only in the cycle after E3
      num = 3'd1; rob[0] = 7'h15; dst[0] = 8'h2A;
      @(posedge clk); #1;
      num = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("single_executed", executed, (i == 3));
         if (i == 3) begin
            chk("single_reg", executed_reg, 8'h2A);
            chk("single_rob", done_rob,     7'h15);
         end
      end
      @(posedge clk); #1;
      idle(4);

      // Burst ordering: 1..4 then 5,6
      peak = 0; max_run = 0;
      next_rob = 1;
      issue(4);
      issue(2);
      drain("burst_drain");
      chk("burst_peak_occ",    peak,    5);
      chk("burst_consecutive", max_run, 6);

      // Backpressure with one protocol violation while stalled
      saw_stall = 1'b0;
      next_rob  = 10;
      ok = 0;
      for (int c = 0; c < 40; c++) begin
         if (m_stall && ok == 0) begin
            issue(3);
            ok = 1;
         end else if (m_stall) begin
            issue(0);
         end else begin
            issue(4);
         end
      end
      chk("bp_saw_stall",  saw_stall, 1);
      chk("bp_violation",  ok,        1);
      drain("bp_drain");
      chk("ovf_sticky", overflow, 1);

      // Reset clears overflow; clamp 6 -> 4 sets it again
      rst_n = 1'b0;
      #1;
      chk("rst_clears_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      next_rob = 100;
      issue(6);
      idle(2);
      chk("clamp_ovf", overflow, 1);
      drain("clamp_drain");

      // Wrap-around through the 8-deep instance
      issued8 = 0;
      for (int c = 0; c < 400 && issued8 < 40; c++) begin
         n = 40 - issued8;
         if (n > 4) n = 4;
         if (stall8) n = 0;
         for (int k = 0; k < 4; k++) begin
            rob8[k] = 7'(issued8 + k);
            dst8[k] = 8'($urandom);
            if (k < n) sb8.push_back({rob8[k], dst8[k]});
         end
         num8 = 3'(n);
         @(posedge clk); #1;
         num8 = '0;
         issued8 += n;
      end
      for (int c = 0; c < 200 && bc8 < 40; c++) @(posedge clk);
      idle(3);
      chk("wrap_issued",   issued8,        40);
      chk("wrap_count",    bc8,            40);
      chk("wrap_max_occ",  (max_occ8 <= 8), 1);
      chk("wrap_sb_empty", sb8.size(),     0);
      chk("wrap_overflow", overflow8,      0);

      // Reset with 6 buffered and 4 in flight
      next_rob = 60;
      issue(4);
      issue(3);
      issue(0);
      issue(4);
      chk("pre_rst_occ",      occupancy,  6);
      chk("pre_rst_inflight", m_level(),  10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_executed",  executed,     0);
      chk("arst_reg",       executed_reg, 0);
      chk("arst_rob",       done_rob,     0);
      chk("arst_occupancy", occupancy,    0);
      chk("arst_stall",     stall,        0);
      chk("arst_overflow",  overflow,     0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (executed) stale++;
      end
      chk("post_rst_stale", stale, 0);
      chk("post_rst_stall", stall, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exec_wakeup_bcast.md
# exec_wakeup_bcast

Execution-completion broadcaster on the far side of the 4-wide issue queue. It accepts up to four issued ops per cycle as robIdx and destination physical register pairs. It models a fixed-latency execution pipe, buffers completions in an in-order FIFO, and retires one completion per cycle. Each retirement drives the single `executed`/`executedReg` wakeup broadcast back into the issue queue and the completing robIdx toward the ROB.

## Interface
- `LAT`, default 2: execution latency in pipe stages; legal range 1..4.
- `DEPTH`, default 16: completion FIFO entries; power of two, at least 8.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `numIssued`  in  3  count of valid issue slots this cycle; slot k is valid iff k < numIssued.
- `issued0`..`issued3`  in  7 each  robIdx of issue slots 0..3.
- `dest0`..`dest3`  in  8 each  destination physical register of slots 0..3.
- `executed`  out  1  registered; a completion is being broadcast this cycle.
- `executedReg`  out  8  registered; destination register of the broadcast completion.
- `doneRobIdx`  out  7  registered; robIdx of the broadcast completion.
- `stall`  out  1  upstream must present numIssued=0 while high.
- `occupancy`  out  log2(DEPTH)+1  current FIFO entry count.
- `overflow`  out  1  sticky error flag; cleared only by reset.

## Operation
- Issue capture: each edge samples slots 0..numIssued-1 into pipe stage 1 as one group.
  - A group is up to 4 {robIdx, dest} pairs plus a 3-bit count.
  - numIssued values 5..7 are clamped to 4 and set `overflow`.
- Pipe: groups advance one stage per edge through `LAT` stages. No stalling inside the pipe.
- FIFO write: the group leaving stage LAT is pushed in slot order (slot 0 first), using 0..4 entries, at the same edge.
- FIFO pop: when occupancy is nonzero, the head pops at each edge and loads `executed=1`, `executedReg`, `doneRobIdx`.
  - When the FIFO is empty, that edge loads `executed=0`, `executedReg=0`, `doneRobIdx=0`.
- Simultaneous push and pop: the pop takes the pre-edge head. Next occupancy = occupancy + pushCount − pop.
  - A push into an empty FIFO is not popped in the same edge; there is no bypass.
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Inflight = sum of group counts over all pipe stages; width 5 bits.
- `stall` = (occupancy + inflight) > DEPTH−4, computed in 7 bits from registered state only, with no input-to-output path.
  - This guarantees that any accepted group can never overflow the FIFO.
- Protocol violation: if numIssued≠0 while `stall`=1, the group is dropped (stage 1 loads count 0) and `overflow` is set.
- Reset values: all outputs 0, pipe counts 0, pointers 0, occupancy 0, `stall`=0, `overflow`=0.
- Reset asserted mid-operation discards all inflight and buffered ops with no broadcast. Operation resumes on the first edge after deassertion.

## Timing
- Minimum latency, for ops sampled at edge E0 into an empty FIFO:
  - ops occupy stage 1 after E0 and stage LAT after E(LAT−1);
  - the FIFO write happens at E(LAT);
  - slot 0 is broadcast in the cycle after E(LAT+1), slot k in the cycle after E(LAT+1+k).
- Throughput: at most one broadcast per cycle; completions leave in issue order, and by slot index within a group.
- `stall` reflects the state after the current edge. Upstream samples it in the same cycle it drives numIssued.
- `occupancy` and `overflow` are registered and valid in the cycle after the causing edge.

## Test plan
- Single op, LAT=2: numIssued=1, issued0=7'h15, dest0=8'h2A at E0.
  - Required: `executed`=1 with `executedReg`=8'h2A and `doneRobIdx`=7'h15 only in the cycle after E3; 0 in all other cycles.
- Burst ordering: numIssued=4 with robIdx 1,2,3,4 at E0, then numIssued=2 with robIdx 5,6 at E1.
  - Required: broadcasts of robIdx 1,2,3,4,5,6 on six consecutive cycles; `occupancy` peaks at 5.
- Backpressure, DEPTH=16: issue 4 ops every cycle.
  - Required: `stall` rises once occupancy+inflight exceeds 12; no entry is lost; `overflow` stays 0; every robIdx is broadcast exactly once.
- Violation: force numIssued=3 while `stall`=1.
  - Required: those 3 ops are never broadcast; `overflow`=1 until reset. numIssued=6 is clamped to 4 and also sets `overflow`.
- Wrap-around: stream 40 ops through DEPTH=8.
  - Required: in-order broadcast across pointer wrap; `occupancy` never exceeds 8.
- Reset mid-operation: assert `reset`=0 asynchronously with 6 ops buffered and 4 inflight.
  - Required: all outputs go to 0 immediately; after release, no stale broadcasts and `stall`=0.
